// File: rtl/alu_result_queue.sv
// alu_result_queue
// Buffers up to DEPTH signed ALU results. Each entry holds the opcode, the
// result, and status flags computed when the entry is written. Entries are
// delivered over a valid/ready handshake. The queue also detects
// divide-by-zero, which the ALU does not.
//
// Ports
//   clk, rst        single clock; asynchronous active-high reset
//   in_valid        producer offers in_op/in_b/in_result this cycle
//   in_ready        queue can accept (low while in reset or when full)
//   in_op           opcode that produced in_result
//   in_b            B operand, used only for the divide-by-zero check
//   in_result       signed ALU result
//   out_valid       head entry present
//   out_ready       consumer takes the head entry this cycle
//   out_result      head result (0 when empty)
//   out_op          head opcode (0 when empty)
//   out_zero        head result == 0
//   out_neg         head result sign bit
//   out_dz          head entry was a divide with B == 0
//   count           number of occupied entries
module alu_result_queue #(
   parameter int DEPTH = 4,
   parameter int RW    = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2:0]                 in_op,
   input  logic [15:0]                in_b,
   input  logic [RW-1:0]              in_result,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [RW-1:0]              out_result,
   output logic [2:0]                 out_op,
   output logic                       out_zero,
   output logic                       out_neg,
   output logic                       out_dz,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [2:0] OP_DIV = 3'b011;

   logic [RW-1:0] mem_result [DEPTH];
   logic [2:0]    mem_op     [DEPTH];
   logic          mem_zero   [DEPTH];
   logic          mem_neg    [DEPTH];
   logic          mem_dz     [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic          push;
   logic          pop;
   logic          wr_dz;
   logic [RW-1:0] wr_result;

   assign in_ready  = !rst && (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // On divide-by-zero the ALU output is garbage; store a clean zero instead.
   assign wr_dz     = (in_op == OP_DIV) && (in_b == 16'd0);
   assign wr_result = wr_dz ? '0 : in_result;

   // Storage is not reset; stale contents are masked by count == 0.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_result[wr_ptr] <= wr_result;
         mem_op[wr_ptr]     <= in_op;
         mem_zero[wr_ptr]   <= (wr_result == '0);
         mem_neg[wr_ptr]    <= wr_result[RW-1];
         mem_dz[wr_ptr]     <= wr_dz;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   always_comb begin
      out_result = '0;
      out_op     = '0;
      out_zero   = 1'b0;
      out_neg    = 1'b0;
      out_dz     = 1'b0;
      if (out_valid) begin
         out_result = mem_result[rd_ptr];
         out_op     = mem_op[rd_ptr];
         out_zero   = mem_zero[rd_ptr];
         out_neg    = mem_neg[rd_ptr];
         out_dz     = mem_dz[rd_ptr];
      end
   end

endmodule

// File: tb/tb_alu_result_queue.sv
module tb_alu_result_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [15:0] in_b;
   logic [31:0] in_result;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [2:0]  out_op;
   logic        out_zero;
   logic        out_neg;
   logic        out_dz;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_bad = 0;

   alu_result_queue #(.DEPTH(4), .RW(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_b       (in_b),
      .in_result  (in_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_op     (out_op),
      .out_zero   (out_zero),
      .out_neg    (out_neg),
      .out_dz     (out_dz),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // one rising edge, then settle at the falling edge for checks and new drives
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push1(input logic [2:0] op, input logic [15:0] b, input logic [31:0] r);
      in_valid  = 1'b1;
      in_op     = op;
      in_b      = b;
      in_result = r;
      step();
      in_valid  = 1'b0;
   endtask

   task automatic pop1();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   logic [31:0] seq [12];

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_op = '0; in_b = '0; in_result = '0;
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_out_result", out_result, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_in_ready", in_ready, 1);

      // basic add
      push1(3'b000, 16'd15, 32'd75);
      chk("add_valid", out_valid, 1);
      chk("add_result", out_result, 75);
      chk("add_op", out_op, 0);
      chk("add_flags", {out_zero, out_neg, out_dz}, 3'b000);
      chk("add_count", count, 1);
      pop1();
      chk("add_pop_valid", out_valid, 0);
      chk("add_pop_count", count, 0);
      chk("add_pop_result", out_result, 0);

      // signed divide, then zero result
      push1(3'b011, 16'd40, 32'hFFFF_FFFE);
      push1(3'b001, 16'd8000, 32'd0);
      chk("div_result", out_result, 32'hFFFF_FFFE);
      chk("div_op", out_op, 3);
      chk("div_flags", {out_zero, out_neg, out_dz}, 3'b010);
      chk("div_count", count, 2);
      pop1();
      chk("sub_zero", out_zero, 1);
      chk("sub_result", out_result, 0);
      chk("sub_op", out_op, 1);
      pop1();
      chk("div_drain", count, 0);

      // divide by zero vs multiply by zero
      push1(3'b011, 16'd0, 32'hDEAD_BEEF);
      push1(3'b010, 16'd0, 32'hDEAD_BEEF);
      chk("dz_result", out_result, 0);
      chk("dz_flags", {out_zero, out_neg, out_dz}, 3'b101);
      pop1();
      chk("mul_result", out_result, 32'hDEAD_BEEF);
      chk("mul_flags", {out_zero, out_neg, out_dz}, 3'b010);
      pop1();
      chk("dz_drain", count, 0);

      // full / backpressure
      for (int i = 0; i < 4; i++) push1(3'b000, 16'd1, 32'(100 + i));
      chk("full_count", count, 4);
      chk("full_in_ready", in_ready, 0);
      in_valid = 1'b1; in_result = 32'd104;
      step();
      chk("full_reject_count", count, 4);
      chk("full_head", out_result, 100);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("nobypass_count", count, 3);
      chk("nobypass_head", out_result, 101);
      chk("nobypass_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("late_push_count", count, 4);
      for (int i = 0; i < 4; i++) begin
         chk("drain_order", out_result, 32'(101 + i));
         pop1();
      end
      chk("full_drain", count, 0);

      // simultaneous push/pop across pointer wrap
      seq[0] = 32'd1000; seq[1] = 32'd1001;
      for (int i = 1; i <= 10; i++) seq[i + 1] = 32'(i);
      push1(3'b000, 16'd1, seq[0]);
      push1(3'b000, 16'd1, seq[1]);
      for (int i = 1; i <= 10; i++) begin
         chk("wrap_head", out_result, seq[i - 1]);
         in_valid = 1'b1; in_result = 32'(i); out_ready = 1'b1;
         step();
         chk("wrap_count", count, 2);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("wrap_tail0", out_result, 9);
      pop1();
      chk("wrap_tail1", out_result, 10);
      pop1();
      chk("wrap_drain", count, 0);

      // asynchronous reset mid-operation
      for (int i = 0; i < 3; i++) push1(3'b000, 16'd1, 32'(7 + i));
      chk("pre_rst_count", count, 3);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_in_ready", in_ready, 1);
      @(negedge clk);
      push1(3'b000, 16'd1, 32'd882);
      chk("post_rst_head", out_result, 882);
      chk("post_rst_count", count, 1);
      pop1();
      chk("post_rst_drain", count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Downstream stage of the 16-bit ALU. Captures each 32-bit signed ALU result together with its opcode and status flags, buffers up to DEPTH results, and presents them to the consumer over a valid/ready handshake. This decouples the combinational ALU from a consumer that may stall. It also flags divide-by-zero, which the ALU itself does not detect.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- RW, 32, result width; matches ALU output width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  producer offers a result this cycle
- in_ready  out  1  queue accepts; = !rst && (count != DEPTH)
- in_op  in  3  opcode that produced in_result (000 add … 111 not B)
- in_b  in  16  B operand of that operation, used only for divide-by-zero check
- in_result  in  RW  signed ALU output
- out_valid  out  1  head entry present; = (count != 0)
- out_ready  in  1  consumer takes head this cycle
- out_result  out  RW  head result; 0 when empty
- out_op  out  3  head opcode; 0 when empty
- out_zero  out  1  head result == 0
- out_neg  out  1  head result[RW-1]
- out_dz  out  1  head was divide (op 011) with B == 0
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Push: in_valid && in_ready at a rising edge writes {op, result', zero, neg, dz} at wr_ptr. Then wr_ptr++ (wraps mod DEPTH).
- Flags are computed at push time from result':
  - dz = (in_op == 3'b011) && (in_b == 16'sd0)
  - result' = dz ? 0 : in_result; the ALU's X/garbage for divide-by-zero is never stored
  - zero = (result' == 0); when dz=1, zero=1 and neg=0
  - neg = result'[RW-1]
- Pop: out_valid && out_ready at a rising edge removes the head. Then rd_ptr++ (wraps mod DEPTH).
- out_* are read combinationally from the entry at rd_ptr, gated to 0 when count == 0.
- Count update:
  - push only: +1
  - pop only: −1
  - both: unchanged
  - neither: unchanged
- Full (count == DEPTH): in_ready = 0. A simultaneous pop does not enable a same-cycle push; there is no bypass.
- Empty (count == 0): out_valid = 0 and out_ready is ignored. A push is not visible on the output in the same cycle; there is no fall-through.
- Pointer wrap: entries are delivered strictly in push order across any number of wraps.
- Ignored stimulus:
  - in_valid with in_ready = 0 has no effect. The producer must hold its data.
  - out_ready with out_valid = 0 has no effect.

## Timing
- Reset (async assert): rd_ptr = wr_ptr = 0 and count = 0 immediately, independent of clk.
  - out_valid = 0; out_result, out_op, out_zero, out_neg, out_dz = 0
  - in_ready = 0 while rst = 1
- Reset release: in_ready = 1 in the first cycle after rst deasserts. The first push is possible at the first rising edge with rst = 0.
- Reset mid-operation: all buffered entries are discarded. Storage contents need not be cleared; they are masked by count = 0.
- Latency: a push at edge N gives out_valid = 1 and head data valid during the cycle after edge N, i.e. 1 cycle.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- in_ready and out_valid depend only on registered count and rst. There are no combinational paths from in_valid to out_*, or from out_ready to in_ready.

## Test plan
- Basic add: after reset, push op=000, result=75, b=15, with out_ready=0.
  - Next cycle: out_valid=1, out_result=75, zero=0, neg=0, dz=0, count=1.
  - Pop: out_valid=0, count=0, out_result=0.
- Signed divide: push op=011, result=−2, b=40.
  - Expect out_result=32'hFFFFFFFE, neg=1, zero=0, dz=0.
  - Then push op=001, result=0, b=8000; after popping the first entry, expect zero=1.
- Divide-by-zero: push op=011, b=0, result=32'hDEADBEEF.
  - Expect out_result=0, dz=1, zero=1, neg=0.
  - Same b=0 with op=010 (multiply): expect dz=0, result stored unchanged.
- Full/backpressure: hold out_ready=0 and push 100, 101, 102, 103.
  - count=4, in_ready=0; a fifth push of 104 is not accepted.
  - Assert out_ready with in_valid held: 100 pops. 104 is accepted the cycle after (no bypass).
  - Drain order: 101, 102, 103, 104.
- Wrap/simultaneous: with count=2, drive in_valid and out_ready together for 10 cycles using results 1..10.
  - count stays 2; outputs appear in push order across pointer wrap.
- Reset mid-operation: with count=3, assert rst asynchronously between clock edges.
  - Expect out_valid=0, count=0, in_ready=0 immediately, and no stale entry after release.
  - The next pushed value (e.g. 882) is the first one popped.
